// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and the memory.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemRdata;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemValid,
    input  ImemRdata
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemValid,
    output ImemRdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: FETCH/WAIT/HOLD sequencer with one outstanding request,
// redirect handling with kill of in-flight data, and the IF/ID pipeline register.
module fetch_stage (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 BranchTakenE,
  input  logic [31:0]          ALUResultE,
  input  logic                 PCSrcW,
  input  logic [31:0]          ResultW,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstD,
  output logic [31:0]          PCPlus8D,
  output logic                 ValidD,
  output logic [31:0]          PCF
);

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_r;
  logic        kill_r;
  logic [31:0] hold_r;

  logic        redirect_s;
  logic [31:0] target_s;
  logic        flush_s;
  logic [31:0] pc_inc_s;
  logic [31:0] pc_plus8_s;
  logic        load_s;
  logic [31:0] load_data_s;

  // Redirect selection, PC arithmetic and the IF/ID load decision.
  always_comb begin
    redirect_s  = BranchTakenE | PCSrcW;
    target_s    = (BranchTakenE ? ALUResultE : ResultW) & 32'hFFFF_FFFC;
    flush_s     = FlushD | redirect_s;
    pc_inc_s    = PCF + 32'd4;
    pc_plus8_s  = PCF + 32'd8;
    load_s      = 1'b0;
    load_data_s = imem.ImemRdata;
    case (state_r)
      S_WAIT: begin
        if (imem.ImemValid && !kill_r && !redirect_s && !StallD) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      S_HOLD: begin
        if (!redirect_s && !StallD) begin
          load_s      = 1'b1;
          load_data_s = hold_r;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // The request is withheld in the reset cycle and when a redirect is pending.
  assign imem.ImemReq  = (state_r == S_FETCH) && !redirect_s && !reset;
  assign imem.ImemAddr = PCF;

  // Fetch sequencer: state, fetch PC, kill flag and hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      PCF     <= 32'd0;
      kill_r  <= 1'b0;
      hold_r  <= 32'd0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (redirect_s) begin
            PCF     <= target_s;
            state_r <= S_FETCH;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_s) begin
            PCF <= target_s;
            if (imem.ImemValid) begin
              kill_r  <= 1'b0;
              state_r <= S_FETCH;
            end else begin
              kill_r  <= 1'b1;
              state_r <= S_WAIT;
            end
          end else if (imem.ImemValid) begin
            if (kill_r) begin
              kill_r  <= 1'b0;
              state_r <= S_FETCH;
            end else if (!StallD) begin
              PCF     <= pc_inc_s;
              state_r <= S_FETCH;
            end else begin
              hold_r  <= imem.ImemRdata;
              state_r <= S_HOLD;
            end
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (redirect_s) begin
            PCF     <= target_s;
            state_r <= S_FETCH;
          end else if (!StallD) begin
            PCF     <= pc_inc_s;
            state_r <= S_FETCH;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r <= S_FETCH;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: a flush beats both a stall and a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      InstD    <= NOP_INSTR;
      PCPlus8D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (flush_s) begin
      InstD    <= NOP_INSTR;
      PCPlus8D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (load_s) begin
      InstD    <= load_data_s;
      PCPlus8D <= pc_plus8_s;
      ValidD   <= 1'b1;
    end else begin
      InstD    <= InstD;
      PCPlus8D <= PCPlus8D;
      ValidD   <= ValidD;
    end
  end

endmodule
